// File: rtl/gate_sweep.sv
// Gate evaluator with an exhaustive-sweep mode: walks every N-bit
// vector through the selected gate and counts the vectors that yield 1.
module gate_sweep #(
  parameter int N    = 2,
  parameter int HOLD = 20
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [2:0]   mode,
  input  logic [N-1:0] x_in,
  output logic [N-1:0] x,
  output logic         z,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   mode_q, mode_d;
  logic [N-1:0] vec_q, vec_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N:0]   ones_q, ones_d;
  logic [N-1:0] x_q, x_d;
  logic         z_q, z_d;

  function automatic logic gate_f(
    input logic [2:0]   m,
    input logic [N-1:0] v
  );
    logic r;
    case (m)
      3'b000:  r = &v;
      3'b001:  r = |v;
      3'b010:  r = ^v;
      3'b011:  r = ~&v;
      3'b100:  r = ~|v;
      3'b101:  r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    ones_d  = ones_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          vec_d   = '0;
          hold_d  = '0;
          ones_d  = '0;
        end
      end
      RUN: begin
        if (hold_q == HLAST) begin
          hold_d = '0;
          vec_d  = vec_q + 1'b1;
          if (gate_f(mode_q, vec_q)) begin
            ones_d = ones_q + 1'b1;
          end
          if (&vec_q) begin
            state_d = DONE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // x shows the vector for the cycle being entered
    x_d = (state_d == RUN) ? vec_d : x_in;
    z_d = gate_f((state_q == RUN) ? mode_q : mode, x_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      mode_q  <= '0;
      vec_q   <= '0;
      hold_q  <= '0;
      ones_q  <= '0;
      x_q     <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      ones_q  <= ones_d;
      x_q     <= x_d;
      z_q     <= z_d;
    end
  end

  assign x    = x_q;
  assign z    = z_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign ones = ones_q;

endmodule

// File: doc/gate_sweep.md
GATE_SWEEP -- requirements
Module: gate_sweep

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning the gate input count; the legal range is 1..8.
REQ-002 The block SHALL have parameter HOLD, default 20, meaning the clock cycles each sweep vector is held; the legal range is >=1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a high level for one cycle requests an exhaustive sweep.
REQ-006 The block SHALL have port mode, input, 3 bits, which selects the gate function:
- 000 AND
- 001 OR
- 010 XOR
- 011 NAND
- 100 NOR
- 101 XNOR
- 110 and 111 constant 0
REQ-007 The block SHALL have port x_in, input, N bits: the external gate operands, used when no sweep is running.
REQ-008 The block SHALL have port x, output, N bits: the registered vector currently applied to the gate.
REQ-009 The block SHALL have port z, output, 1 bit: the registered gate result of x.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a sweep runs.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse at sweep end.
REQ-012 The block SHALL have port ones, output, N+1 bits: the count of sweep vectors whose gate result was 1.

Function
REQ-013 The block SHALL implement the FSM states IDLE, RUN and DONE, with the following transitions:
- IDLE -> RUN on start=1.
- RUN -> DONE after the last vector's final hold cycle.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-014 In IDLE and DONE, the block SHALL register x <= x_in every cycle and SHALL evaluate z using the live mode input.
REQ-015 On the start edge in IDLE, the block SHALL:
- latch mode into an internal mode register;
- clear ones to 0;
- clear the vector counter and the hold counter to 0;
- set busy=1.
REQ-016 In RUN, the block SHALL drive x from the vector counter, starting at 0.
REQ-017 In RUN, the hold counter SHALL count 0..HOLD-1; at HOLD-1 the vector counter SHALL increment and the hold counter SHALL wrap to 0.
REQ-018 The vector counter SHALL span 0..2^N-1, so a sweep lasts exactly 2^N*HOLD cycles with busy=1.
REQ-019 In RUN, the gate function SHALL use the latched mode; changes on the mode input during RUN SHALL have no effect.
REQ-020 The z output SHALL equal f(x) one clock after x changes (latency 1); z SHALL be a register, never combinational from inputs.
REQ-021 During RUN, ones SHALL increment by 1 on each vector's hold cycle HOLD-1 when f(vector)=1, with f evaluated under the latched mode.
REQ-022 The ones value SHALL never wrap; its maximum is 2^N, which fits in N+1 bits.
REQ-023 On the edge that finishes vector 2^N-1, the block SHALL enter DONE with done=1 and busy=0 for exactly 1 cycle.
REQ-024 After DONE, ones SHALL hold its value until the next accepted start.
REQ-025 Any start asserted in RUN SHALL be ignored.
REQ-026 Any start asserted in DONE SHALL be ignored; a new start SHALL be accepted only in IDLE.
REQ-027 When HOLD=1, the vector SHALL advance every cycle; all other rules SHALL be unchanged.
REQ-028 When N=1, the gate functions SHALL reduce over a single bit: AND/OR/XOR yield x[0]; NAND/NOR/XNOR yield ~x[0].
REQ-029 The gate functions SHALL be reduction operators over all N bits of x.

Reset
REQ-030 While rstn=0, the block SHALL immediately force:
- state = IDLE;
- x = 0, z = 0;
- busy = 0, done = 0, ones = 0;
- all internal counters and the latched mode = 0.
REQ-031 Asserting rstn in the middle of a sweep SHALL abort the sweep with no done pulse; after release the block SHALL be in IDLE.
REQ-032 After rstn is released, the first rising clock edge SHALL resume normal operation; no start is required to track x_in.

Verification
REQ-033 The bench SHALL cover a basic OR sweep:
- Stimulus: N=2, HOLD=20, mode=001, start pulse.
- Response: x = 00, 01, 10, 11, each held for 20 cycles; busy=1 for 80 cycles; done pulses once; ones=3; z lags x by 1 cycle.
REQ-034 The bench SHALL cover AND and NAND sweeps:
- Stimulus: N=2, HOLD=20, mode=000, then mode=011.
- Response: ones=1 for AND, then ones=3 for NAND.
REQ-035 The bench SHALL cover an XOR sweep with a mid-sweep mode change:
- Stimulus: N=3, HOLD=1, mode=010; mode changed to 000 during RUN.
- Response: the sweep lasts 8 cycles; ones=4; the mode change is ignored.
REQ-036 The bench SHALL cover a reserved mode with a start during RUN:
- Stimulus: mode=111 with start; start pulsed again during RUN.
- Response: ones=0; there is only one sweep and one done pulse.
REQ-037 The bench SHALL cover reset mid-sweep:
- Stimulus: N=2, HOLD=20; rstn=0 at cycle 30 of the sweep.
- Response: busy=0, ones=0 and x=0 at once; no done pulse; after release, x tracks x_in.
REQ-038 The bench SHALL cover idle passthrough:
- Stimulus: N=2, mode=001 in IDLE; x_in stepped through 00, 01, 10, 11.
- Response: x follows x_in 1 cycle later; z = 0, 1, 1, 1, each 1 cycle after x.
